// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance-counter bank and the CPU top that wires its events.
package perf_pkg;

  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_t;

  localparam int PC_MODE_WRAP = 0;
  localparam int PC_MODE_SAT  = 1;

  localparam int EVT_RETIRE   = 0;
  localparam int EVT_BR_TAKEN = 1;
  localparam int EVT_MISPRED  = 2;
  localparam int EVT_STALL    = 3;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, event and readout bundle between the pipeline (master) and the counter bank (slave).
interface perf_counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = $clog2(NUM_CH + 1);

  logic                      strcnt;
  logic                      stpcnt;
  logic                      clr;
  logic [NUM_CH-1:0]         evt;
  logic [NUM_CH-1:0]         ch_en;
  logic                      snap;
  logic [SEL_W-1:0]          rd_sel;
  logic [CNT_W-1:0]          rd_data;
  logic [(NUM_CH+1)*CNT_W-1:0] cnt_flat;
  logic [NUM_CH:0]           ovf;
  logic                      running;

  modport master (
    output strcnt, stpcnt, clr, evt, ch_en, snap, rd_sel,
    input  rd_data, cnt_flat, ovf, running
  );

  modport slave (
    input  strcnt, stpcnt, clr, evt, ch_en, snap, rd_sel,
    output rd_data, cnt_flat, ovf, running
  );

endinterface

// File: rtl/perf_counter_bank_ctr_cell.sv
// One event counter with wrap-or-saturate increment and a sticky overflow flag.
module perf_ctr_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = PC_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] v);
    if (v == ALL_ONES) begin
      return (SAT_MODE == PC_MODE_SAT) ? ALL_ONES : '0;
    end
    return v + ONE;
  endfunction

  // clr outranks inc so a clear in a counting cycle leaves the cell at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= step(cnt);
      if (cnt == ALL_ONES) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel performance-monitor bank: run FSM, NUM_CH event counters plus a cycle counter,
// sticky overflow flags and a snapshot shadow set with registered readout.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = PC_MODE_WRAP
) (
  input  logic               clk,
  input  logic               rst_n,
  perf_counter_bank_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_CH + 1);
  localparam logic [SEL_W-1:0] CYC_SEL = SEL_W'(NUM_CH);

  pc_state_t        state_q, state_d;
  logic             running_q;
  logic             run;
  logic [NUM_CH:0]  inc;
  logic [NUM_CH:0]  ovf_w;
  logic [CNT_W-1:0] cnt_w    [NUM_CH+1];
  logic [CNT_W-1:0] shadow_q [NUM_CH+1];
  logic [CNT_W-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PC_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == PC_RUN);
    end
  end

  // Simultaneous start and stop cancel out; clr forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = PC_IDLE;
    end else begin
      case (state_q)
        PC_IDLE, PC_HALT: if (bus.strcnt && !bus.stpcnt) state_d = PC_RUN;
        PC_RUN:           if (bus.stpcnt && !bus.strcnt) state_d = PC_HALT;
        default:          state_d = PC_IDLE;
      endcase
    end
  end

  assign run          = (state_q == PC_RUN);
  assign inc[NUM_CH]  = run;
  assign inc[NUM_CH-1:0] = {NUM_CH{run}} & bus.evt & bus.ch_en;

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_cell
    perf_ctr_cell #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr),
      .inc   (inc[g]),
      .cnt   (cnt_w[g]),
      .ovf   (ovf_w[g])
    );
    assign bus.cnt_flat[g*CNT_W +: CNT_W] = cnt_w[g];
  end

  // Shadows capture pre-increment values and deliberately survive clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_CH; i++) shadow_q[i] <= '0;
    end else if (bus.snap && !bus.clr) begin
      for (int i = 0; i <= NUM_CH; i++) shadow_q[i] <= cnt_w[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= (bus.rd_sel <= CYC_SEL) ? shadow_q[bus.rd_sel] : '0;
    end
  end

  assign bus.ovf     = ovf_w;
  assign bus.rd_data = rd_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrap-mode and a saturate-mode bank (CNT_W=8) share one stimulus
// stream and are checked against an attempt-count model every cycle, plus directed sequences.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NC = 4;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strcnt = 0, stpcnt = 0, clr = 0, snap = 0;
  logic [3:0] evt = '0, ch_en = 4'hF;
  logic [2:0] rd_sel = '0;

  int ntests = 0;
  int nfail  = 0;

  perf_counter_bank_if #(.NUM_CH(NC), .CNT_W(CW)) ifw ();
  perf_counter_bank_if #(.NUM_CH(NC), .CNT_W(CW)) ifs ();

  assign ifw.strcnt = strcnt;  assign ifs.strcnt = strcnt;
  assign ifw.stpcnt = stpcnt;  assign ifs.stpcnt = stpcnt;
  assign ifw.clr    = clr;     assign ifs.clr    = clr;
  assign ifw.evt    = evt;     assign ifs.evt    = evt;
  assign ifw.ch_en  = ch_en;   assign ifs.ch_en  = ch_en;
  assign ifw.snap   = snap;    assign ifs.snap   = snap;
  assign ifw.rd_sel = rd_sel;  assign ifs.rd_sel = rd_sel;

  perf_counter_bank #(.NUM_CH(NC), .CNT_W(CW), .SAT_MODE(PC_MODE_WRAP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(ifw)
  );
  perf_counter_bank #(.NUM_CH(NC), .CNT_W(CW), .SAT_MODE(PC_MODE_SAT)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(ifs)
  );

  always #5 clk = ~clk;

  // Model: each counter is the unbounded number of increments attempted since the last clear
  int att    [5];
  int sh_att [5];
  int rd_att;
  bit m_run;

  function automatic logic [7:0] mval(input int a, input bit sat);
    if (sat && a > 255) return 8'hFF;
    return a[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      att[i] = 0;
      sh_att[i] = 0;
    end
    rd_att = 0;
    m_run  = 0;
  endtask

  task automatic model_step();
    rd_att = (rd_sel <= 3'd4) ? sh_att[rd_sel] : 0;
    if (clr) begin
      for (int i = 0; i < 5; i++) att[i] = 0;
      m_run = 0;
    end else begin
      if (snap) for (int i = 0; i < 5; i++) sh_att[i] = att[i];
      if (m_run) begin
        att[4]++;
        for (int i = 0; i < 4; i++) if (evt[i] && ch_en[i]) att[i]++;
      end
      if (strcnt && !stpcnt) m_run = 1;
      else if (stpcnt && !strcnt) m_run = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [39:0] ew, es;
    logic [4:0]  eo;
    for (int i = 0; i < 5; i++) begin
      ew[i*8 +: 8] = mval(att[i], 1'b0);
      es[i*8 +: 8] = mval(att[i], 1'b1);
      eo[i]        = (att[i] >= 256);
    end
    chk("wrap_cnt",  64'(ifw.cnt_flat), 64'(ew));
    chk("sat_cnt",   64'(ifs.cnt_flat), 64'(es));
    chk("wrap_ovf",  64'(ifw.ovf), 64'(eo));
    chk("sat_ovf",   64'(ifs.ovf), 64'(eo));
    chk("running",   64'({ifw.running, ifs.running}), 64'({m_run, m_run}));
    chk("wrap_rd",   64'(ifw.rd_data), 64'(mval(rd_att, 1'b0)));
    chk("sat_rd",    64'(ifs.rd_data), 64'(mval(rd_att, 1'b1)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    strcnt = 0; stpcnt = 0; clr = 0; snap = 0;
    evt = '0; ch_en = 4'hF; rd_sel = '0;
  endtask

  typedef struct {
    logic       strcnt;
    logic       stpcnt;
    logic [3:0] evt;
    logic       exp_run;
    int         exp_cyc;
    int         exp_ch0;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'h1, 1'b1, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 4'h1, 1'b1, 1, 1};
    tbl[2] = '{1'b0, 1'b0, 4'h1, 1'b1, 2, 2};
    tbl[3] = '{1'b0, 1'b0, 4'h1, 1'b1, 3, 3};
    tbl[4] = '{1'b0, 1'b0, 4'h1, 1'b1, 4, 4};
    tbl[5] = '{1'b0, 1'b1, 4'h1, 1'b0, 5, 5};
    tbl[6] = '{1'b0, 1'b0, 4'h1, 1'b0, 5, 5};
    tbl[7] = '{1'b1, 1'b0, 4'h1, 1'b1, 5, 5};
    tbl[8] = '{1'b0, 1'b0, 4'h1, 1'b1, 6, 6};

    // Reset and idle with events present but no start
    idle_inputs();
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    evt = 4'hF;
    repeat (10) tick();
    chk("idle_cnt", 64'(ifw.cnt_flat), 64'd0);
    chk("idle_ovf", 64'(ifw.ovf), 64'd0);
    chk("idle_run", 64'(ifw.running), 64'd0);

    // Start/stop window, HALT hold, resume
    for (int i = 0; i < 9; i++) begin
      if (i == 7) begin
        idle_inputs();
        evt = 4'h1;
        repeat (20) tick();
        chk("halt_cyc", 64'(ifw.cnt_flat[39:32]), 64'd5);
        chk("halt_ch0", 64'(ifw.cnt_flat[7:0]), 64'd5);
      end
      idle_inputs();
      strcnt = tbl[i].strcnt;
      stpcnt = tbl[i].stpcnt;
      evt    = tbl[i].evt;
      tick();
      chk("tbl_run", 64'(ifw.running), 64'(tbl[i].exp_run));
      chk("tbl_cyc", 64'(ifw.cnt_flat[39:32]), 64'(tbl[i].exp_cyc));
      chk("tbl_ch0", 64'(ifw.cnt_flat[7:0]), 64'(tbl[i].exp_ch0));
    end

    // Wrap and saturate
    idle_inputs(); clr = 1; tick();
    chk("clr_run", 64'(ifw.running), 64'd0);
    idle_inputs(); strcnt = 1; tick();
    idle_inputs(); evt = 4'b0110;
    repeat (255) tick();
    chk("pre_wrap_ch1", 64'(ifw.cnt_flat[15:8]), 64'hFF);
    chk("pre_wrap_ovf1", 64'(ifw.ovf[1]), 64'd0);
    tick();
    chk("wrap_ch1", 64'(ifw.cnt_flat[15:8]), 64'h00);
    chk("wrap_ovf1", 64'(ifw.ovf[1]), 64'd1);
    repeat (44) tick();
    chk("sat_ch2", 64'(ifs.cnt_flat[23:16]), 64'hFF);
    chk("sat_ovf2", 64'(ifs.ovf[2]), 64'd1);
    idle_inputs(); clr = 1; tick();
    chk("clr_ch1", 64'(ifw.cnt_flat[15:8]), 64'd0);
    chk("clr_ovf", 64'(ifw.ovf), 64'd0);
    chk("clr_idle", 64'(ifw.running), 64'd0);

    // Snapshot and readout
    idle_inputs(); strcnt = 1; tick();
    idle_inputs(); evt = 4'h1;
    repeat (7) tick();
    snap = 1; tick();
    chk("snap_live_ch0", 64'(ifw.cnt_flat[7:0]), 64'd8);
    idle_inputs(); rd_sel = 3'd0; tick();
    chk("rd_ch0", 64'(ifw.rd_data), 64'd7);
    rd_sel = 3'd4; tick();
    chk("rd_cyc", 64'(ifw.rd_data), 64'd7);
    rd_sel = 3'd5; tick();
    chk("rd_oob", 64'(ifw.rd_data), 64'd0);

    // Corner cases
    idle_inputs(); clr = 1; tick();
    idle_inputs(); strcnt = 1; stpcnt = 1; tick();
    chk("start_stop_same", 64'(ifw.running), 64'd0);
    idle_inputs(); clr = 1; strcnt = 1; tick();
    chk("clr_beats_start", 64'(ifw.running), 64'd0);
    idle_inputs(); strcnt = 1; tick();
    idle_inputs(); evt = 4'hF; ch_en = 4'b0111;
    repeat (5) tick();
    chk("ch3_frozen", 64'(ifw.cnt_flat[31:24]), 64'd0);
    chk("ch2_counts", 64'(ifw.cnt_flat[23:16]), 64'd5);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_cnt", 64'(ifw.cnt_flat), 64'd0);
    chk("async_rst_run", 64'(ifw.running), 64'd0);
    check_all();
    #2 rst_n = 1'b1;
    idle_inputs(); evt = 4'hF;
    repeat (3) tick();
    chk("no_resume", 64'(ifw.cnt_flat[39:32]), 64'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      clr    = ($urandom_range(0, 63) == 0);
      strcnt = ($urandom_range(0, 7) == 0);
      stpcnt = ($urandom_range(0, 9) == 0);
      snap   = ($urandom_range(0, 7) == 0);
      evt    = 4'($urandom);
      ch_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rd_sel = 3'($urandom_range(0, 7));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
